// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, instruction memory and the hazard/branch logic.
// The fetch stage is the master: it drives the imem address and the IF/ID outputs.
interface fetch_stage_if #(
   parameter int N = 64
);
   logic [N-1:0] IM_addr;
   logic [31:0]  IM_readData;
   logic         stall;
   logic         PCSrc;
   logic [N-1:0] branch_target;
   logic [31:0]  IF_ID_instr;
   logic [N-1:0] IF_ID_pc;
   logic         IF_ID_valid;
   logic [31:0]  fetch_count;

   modport master (
      output IM_addr,
      input  IM_readData,
      input  stall,
      input  PCSrc,
      input  branch_target,
      output IF_ID_instr,
      output IF_ID_pc,
      output IF_ID_valid,
      output fetch_count
   );

   modport slave (
      input  IM_addr,
      output IM_readData,
      output stall,
      output PCSrc,
      output branch_target,
      input  IF_ID_instr,
      input  IF_ID_pc,
      input  IF_ID_valid,
      input  fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID pipeline register and a
// saturating count of valid instructions delivered to decode.
module fetch_stage #(
   parameter int           N        = 64,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);
   logic [N-1:0] pc_q;
   logic [31:0]  instr_q;
   logic [N-1:0] ifid_pc_q;
   logic         valid_q;
   logic [31:0]  fetch_count_q;

   assign bus.IM_addr     = pc_q;
   assign bus.IF_ID_instr = instr_q;
   assign bus.IF_ID_pc    = ifid_pc_q;
   assign bus.IF_ID_valid = valid_q;
   assign bus.fetch_count = fetch_count_q;

   // Redirect beats stall: a taken branch must squash the wrong-path word even
   // while the hazard unit is holding the pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         ifid_pc_q     <= '0;
         valid_q       <= 1'b0;
         fetch_count_q <= 32'h0;
      end else if (bus.PCSrc) begin
         pc_q      <= {bus.branch_target[N-1:2], 2'b00};
         instr_q   <= 32'h0;
         ifid_pc_q <= '0;
         valid_q   <= 1'b0;
      end else if (!bus.stall) begin
         pc_q      <= pc_q + N'(4);
         instr_q   <= bus.IM_readData;
         ifid_pc_q <= pc_q;
         valid_q   <= 1'b1;
         if (fetch_count_q != 32'hFFFF_FFFF)
            fetch_count_q <= fetch_count_q + 32'd1;
      end
   end
endmodule
